// File: rtl/tone_pkg.sv
// Shared constants for the tone generator: note half-periods, octave codes, FSM encoding.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Contents: middle-octave half-period counts at 100 MHz, octave select codes,
// two-state FSM encoding, silence note code and small helper functions.
package tone_pkg;

   // Counter width; large enough for the low-octave "do" half-period (382226).
   localparam int CNT_W = 19;

   // Middle-octave half-period counts in clk cycles.
   localparam logic [17:0] H_DO = 18'd191113;
   localparam logic [17:0] H_RE = 18'd170262;
   localparam logic [17:0] H_MI = 18'd151686;
   localparam logic [17:0] H_FA = 18'd143172;
   localparam logic [17:0] H_SO = 18'd127551;
   localparam logic [17:0] H_LA = 18'd113636;
   localparam logic [17:0] H_SI = 18'd101239;

   // Octave select codes; code 3 is an alias of the middle octave.
   localparam logic [1:0] OCT_LOW     = 2'd0;
   localparam logic [1:0] OCT_MID     = 2'd1;
   localparam logic [1:0] OCT_HIGH    = 2'd2;
   localparam logic [1:0] OCT_MID_ALT = 2'd3;

   // FSM state encoding.
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_PLAY = 1'b1;

   // Note code meaning "no tone".
   localparam logic [3:0] NOTE_SILENCE = 4'd0;

   // Only codes 1..7 (do..si) produce a tone; 0 and 8..15 are silence.
   function automatic logic note_is_valid(input logic [3:0] code);
      return (code >= 4'd1) && (code <= 4'd7);
   endfunction

   // Middle-octave half-period for a 3-bit note index; 0 for silence.
   function automatic logic [17:0] base_half(input logic [2:0] note);
      logic [17:0] h;
      case (note)
         3'd1:    h = H_DO;
         3'd2:    h = H_RE;
         3'd3:    h = H_MI;
         3'd4:    h = H_FA;
         3'd5:    h = H_SO;
         3'd6:    h = H_LA;
         3'd7:    h = H_SI;
         default: h = 18'd0;
      endcase
      return h;
   endfunction

endpackage

// File: rtl/tone_generator_if.sv
// Controller <-> tone generator bundle: note request in, speaker/status out.
// Latency: n/a (wires only).
// Backpressure: none; the generator samples note requests only at period boundaries.
//
// Signals: note_in[3:0], octave[1:0], (vol[1:0] when TONE_GEN_VOLUME_EN is defined)
// driven by the controller; speaker, playing, cur_note[3:0] driven by the generator.
interface tone_generator_if;
   logic [3:0] note_in;
   logic [1:0] octave;
`ifdef TONE_GEN_VOLUME_EN
   logic [1:0] vol;
`endif
   logic       speaker;
   logic       playing;
   logic [3:0] cur_note;

   // Controller side.
   modport master (
      output note_in,
      output octave,
`ifdef TONE_GEN_VOLUME_EN
      output vol,
`endif
      input  speaker,
      input  playing,
      input  cur_note
   );

   // Generator side.
   modport slave (
      input  note_in,
      input  octave,
`ifdef TONE_GEN_VOLUME_EN
      input  vol,
`endif
      output speaker,
      output playing,
      output cur_note
   );
endinterface

// File: rtl/tone_period_lut.sv
// Maps (note, octave) to the half-period count, scaled down by DIV.
// Latency: combinational.
// Backpressure: none.
//
// Ports: note[2:0], octave[1:0] in; half_len[18:0] out; period_len[19:0] out
// when TONE_GEN_VOLUME_EN is defined (full period, floor(2*H_oct/DIV)).
// The only place octave scaling happens: low = 2*H, high = H>>1.
module tone_period_lut
   import tone_pkg::*;
#(
   parameter int DIV = 1
)
(
   input  logic [2:0]       note,
   input  logic [1:0]       octave,
`ifdef TONE_GEN_VOLUME_EN
   output logic [CNT_W:0]   period_len,
`endif
   output logic [CNT_W-1:0] half_len
);
   localparam logic [21:0] DIV_W = 22'(DIV);

   logic [17:0] base;
   logic [21:0] scaled;

   always_comb begin
      base = base_half(note);
      case (octave)
         OCT_LOW:              scaled = {3'b0, base, 1'b0};
         OCT_HIGH:             scaled = {4'b0, base} >> 1;
         OCT_MID, OCT_MID_ALT: scaled = {4'b0, base};
         default:              scaled = {4'b0, base};
      endcase
      half_len = CNT_W'(scaled / DIV_W);
`ifdef TONE_GEN_VOLUME_EN
      // Divide the doubled count rather than doubling the quotient so the
      // period keeps the fraction lost in the half-period rounding.
      period_len = (CNT_W+1)'({scaled[20:0], 1'b0} / DIV_W);
`endif
   end
endmodule

// File: rtl/tone_generator.sv
// Square-wave buzzer driver: plays note do..si in one of three octaves until silenced.
// Latency: speaker/playing rise one clk after a valid note appears in IDLE.
// Backpressure: none; note/octave (and vol) are sampled only at period boundaries, others ignored.
//
// Ports: clk, rst (sync, active-high); tone (tone_generator_if.slave) carrying
// note_in/octave[/vol] in and speaker/playing/cur_note out.
// Optional feature: TONE_GEN_VOLUME_EN adds a duty-cycle (volume) control.
module tone_generator
   import tone_pkg::*;
#(
   parameter int DIV = 1
)
(
   input  logic           clk,
   input  logic           rst,
   tone_generator_if.slave tone
);
   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             half;        // 0: first half of period (speaker may be high), 1: second half
   logic [2:0]       note_q;
   logic [1:0]       oct_q;
   logic             speaker_q;
   logic             playing_q;
   logic [3:0]       cur_note_q;

   logic [CNT_W-1:0] half_len;
   logic [CNT_W-1:0] len1;        // length of the second half
   logic [CNT_W-1:0] high_len;    // cycles of the first half with speaker high
   logic [CNT_W-1:0] last_idx;
   logic [CNT_W-1:0] cnt_nxt;
   logic             half_nxt;
   logic             is_last;
   logic             boundary;
   logic             load;
   logic             note_ok;
   logic             start_spk;
   logic             spk_run;

`ifdef TONE_GEN_VOLUME_EN
   logic [1:0]       vol_q;
   logic [CNT_W:0]   period_len;
`endif

   tone_period_lut #(.DIV(DIV)) u_lut (
      .note       (note_q),
      .octave     (oct_q),
`ifdef TONE_GEN_VOLUME_EN
      .period_len (period_len),
`endif
      .half_len   (half_len)
   );

   always_comb begin
`ifdef TONE_GEN_VOLUME_EN
      // The period is split into a first half of H and a second half holding
      // the remainder; the high phase is a prefix of the first half, so the
      // period length never depends on volume.
      len1      = CNT_W'(period_len - {1'b0, half_len});
      high_len  = (vol_q == 2'd0) ? '0 : (half_len >> (2'd3 - vol_q));
      start_spk = (tone.vol != 2'd0);
`else
      len1      = half_len;
      high_len  = half_len;
      start_spk = 1'b1;
`endif
      last_idx = (half ? len1 : half_len) - CNT_W'(1);
      is_last  = (cnt == last_idx);
      note_ok  = note_is_valid(tone.note_in);
      // End of the low half: the only point where a new request is honoured.
      boundary = (state == S_PLAY) && half && is_last;
      load     = note_ok && ((state == S_IDLE) || boundary);

      if (is_last) begin
         cnt_nxt  = '0;
         half_nxt = ~half;
      end else begin
         cnt_nxt  = cnt + CNT_W'(1);
         half_nxt = half;
      end
      // Registered speaker value for the next cycle; glitch-free by construction.
      spk_run = !half_nxt && (cnt_nxt < high_len);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         half       <= 1'b0;
         note_q     <= 3'd0;
         oct_q      <= OCT_LOW;
         speaker_q  <= 1'b0;
         playing_q  <= 1'b0;
         cur_note_q <= NOTE_SILENCE;
`ifdef TONE_GEN_VOLUME_EN
         vol_q      <= 2'd0;
`endif
      end else if (load) begin
         // Start from IDLE or re-latch at a boundary: new high half from count 0.
         state      <= S_PLAY;
         cnt        <= '0;
         half       <= 1'b0;
         note_q     <= tone.note_in[2:0];
         oct_q      <= tone.octave;
         speaker_q  <= start_spk;
         playing_q  <= 1'b1;
         cur_note_q <= tone.note_in;
`ifdef TONE_GEN_VOLUME_EN
         vol_q      <= tone.vol;
`endif
      end else if (boundary) begin
         // Silence requested at the end of a full period; speaker is already low.
         state      <= S_IDLE;
         cnt        <= '0;
         half       <= 1'b0;
         speaker_q  <= 1'b0;
         playing_q  <= 1'b0;
         cur_note_q <= NOTE_SILENCE;
      end else if (state == S_PLAY) begin
         cnt        <= cnt_nxt;
         half       <= half_nxt;
         speaker_q  <= spk_run;
      end
   end

   assign tone.speaker  = speaker_q;
   assign tone.playing  = playing_q;
   assign tone.cur_note = cur_note_q;

endmodule
